// File: rtl/fpga_button_conditioner.sv
// rtl/fpga_button_conditioner.sv - synchronise, debounce and edge-detect raw push-button pins
module fpga_button_conditioner #(
    parameter int NrOfButtons   = 2,
    parameter int SyncStages    = 2,
    parameter int TickReload    = 50000,
    parameter int DebounceTicks = 20,
    parameter int CntBits       = 5
) (
    input  logic                   FPGA_GlobalClock,
    input  logic                   RST,
    input  logic [NrOfButtons-1:0] BTN_RAW,
    output logic [NrOfButtons-1:0] BTN_LEVEL,
    output logic [NrOfButtons-1:0] BTN_PRESS,
    output logic [NrOfButtons-1:0] BTN_RELEASE,
    output logic                   SAMPLE_TICK
);

    localparam int PW = (TickReload > 1) ? $clog2(TickReload) : 1;
    localparam logic [PW-1:0]      PRESC_RELOAD = PW'(TickReload - 1);
    localparam logic [CntBits-1:0] CNT_LAST     = CntBits'(DebounceTicks - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } state_t;

    logic [NrOfButtons-1:0] sync_q [SyncStages];
    logic [NrOfButtons-1:0] s_sync;
    logic [PW-1:0]          presc;
    logic                   tick;

    always_ff @(posedge FPGA_GlobalClock) begin
        if (!RST) begin
            for (int i = 0; i < SyncStages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= BTN_RAW;
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_sync = sync_q[SyncStages-1];

    always_ff @(posedge FPGA_GlobalClock) begin
        if (!RST || presc == '0) begin
            presc <= PRESC_RELOAD;
        end else begin
            presc <= presc - PW'(1);
        end
    end

    assign tick        = (presc == '0);
    assign SAMPLE_TICK = tick;

    for (genvar ch = 0; ch < NrOfButtons; ch++) begin : g_ch
        state_t             state;
        logic [CntBits-1:0] cnt;
        logic               level_q;
        logic               press_q;
        logic               release_q;

        // Pulses are cleared every cycle and only set on the accepting tick, so they last one cycle.
        always_ff @(posedge FPGA_GlobalClock) begin
            if (!RST) begin
                state     <= STABLE_LO;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (tick) begin
                    case (state)
                        STABLE_LO: begin
                            if (s_sync[ch]) begin
                                if (DebounceTicks == 1) begin
                                    state   <= STABLE_HI;
                                    cnt     <= '0;
                                    level_q <= 1'b1;
                                    press_q <= 1'b1;
                                end else begin
                                    state <= CHECK_HI;
                                    cnt   <= CntBits'(1);
                                end
                            end else begin
                                cnt <= '0;
                            end
                        end
                        CHECK_HI: begin
                            if (!s_sync[ch]) begin
                                state <= STABLE_LO;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state   <= STABLE_HI;
                                cnt     <= '0;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CntBits'(1);
                            end
                        end
                        STABLE_HI: begin
                            if (!s_sync[ch]) begin
                                if (DebounceTicks == 1) begin
                                    state     <= STABLE_LO;
                                    cnt       <= '0;
                                    level_q   <= 1'b0;
                                    release_q <= 1'b1;
                                end else begin
                                    state <= CHECK_LO;
                                    cnt   <= CntBits'(1);
                                end
                            end else begin
                                cnt <= '0;
                            end
                        end
                        CHECK_LO: begin
                            if (s_sync[ch]) begin
                                state <= STABLE_HI;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state     <= STABLE_LO;
                                cnt       <= '0;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CntBits'(1);
                            end
                        end
                    endcase
                end
            end
        end

        assign BTN_LEVEL[ch]   = level_q;
        assign BTN_PRESS[ch]   = press_q;
        assign BTN_RELEASE[ch] = release_q;
    end

endmodule

// File: tb/tb_fpga_button_conditioner.sv
// tb/tb_fpga_button_conditioner.sv - scoreboard bench for fpga_button_conditioner
module tb_fpga_button_conditioner;

    localparam int NB   = 2;
    localparam int SS   = 2;
    localparam int TR   = 4;
    localparam int DT   = 3;
    localparam int MAXE = 8000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          sample_tick;

    always #5 clk = ~clk;

    fpga_button_conditioner #(
        .NrOfButtons   (NB),
        .SyncStages    (SS),
        .TickReload    (TR),
        .DebounceTicks (DT),
        .CntBits       (2)
    ) dut (
        .FPGA_GlobalClock (clk),
        .RST              (rst_n),
        .BTN_RAW          (btn_raw),
        .BTN_LEVEL        (btn_level),
        .BTN_PRESS        (btn_press),
        .BTN_RELEASE      (btn_release),
        .SAMPLE_TICK      (sample_tick)
    );

    typedef struct {
        int            e;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lvl;
    } pulse_t;

    pulse_t        exp_q[$];
    logic          rst_hist [MAXE];
    logic [NB-1:0] raw_hist [MAXE];
    logic [NB-1:0] lvl_exp  [MAXE];
    logic          tick_exp [MAXE];

    int            n_cmp    = 0;
    int            n_bad    = 0;
    int            edge_cnt = 0;
    int            drv_e    = 1;
    int            last_rst = 0;
    logic [NB-1:0] m_level  = '0;
    bit            samples [NB][$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference: a channel flips once its last DT tick samples all disagree with its level.
    task automatic model_edge(input int e);
        pulse_t p;
        logic   s;
        bit     accept;
        int     n;
        p.e = e;
        p.press = '0;
        p.rel = '0;
        if (!rst_hist[e]) begin
            last_rst = e;
            m_level  = '0;
            for (int ch = 0; ch < NB; ch++) samples[ch].delete();
        end else if ((e - last_rst) % TR == 0) begin
            for (int ch = 0; ch < NB; ch++) begin
                s = (last_rst >= e - SS) ? 1'b0 : raw_hist[e-SS][ch];
                samples[ch].push_back(s);
                n = samples[ch].size();
                accept = (n >= DT);
                for (int k = 1; k <= DT && k <= n; k++) begin
                    if (samples[ch][n-k] == m_level[ch]) accept = 1'b0;
                end
                if (accept) begin
                    if (m_level[ch]) p.rel[ch] = 1'b1;
                    else             p.press[ch] = 1'b1;
                    m_level[ch] = ~m_level[ch];
                    samples[ch].delete();
                end
            end
        end
        tick_exp[e] = rst_hist[e] && ((e - last_rst + 1) % TR == 0);
        lvl_exp[e]  = m_level;
        p.lvl       = m_level;
        if (p.press != '0 || p.rel != '0) exp_q.push_back(p);
    endtask

    task automatic drive(input int n, input logic r, input logic [NB-1:0] raw);
        for (int i = 0; i < n; i++) begin
            if (drv_e < MAXE - 1) begin
                rst_n = r;
                btn_raw = raw;
                rst_hist[drv_e] = r;
                raw_hist[drv_e] = raw;
                model_edge(drv_e);
                @(posedge clk);
                #1;
                drv_e++;
            end
        end
    endtask

    always @(negedge clk) begin
        pulse_t p;
        if (edge_cnt > 0 && edge_cnt < drv_e) begin
            n_cmp++;
            if (btn_level !== lvl_exp[edge_cnt]) begin
                n_bad++;
                $display("FAIL level edge=%0d got=%b want=%b", edge_cnt, btn_level, lvl_exp[edge_cnt]);
            end
            n_cmp++;
            if (sample_tick !== tick_exp[edge_cnt]) begin
                n_bad++;
                $display("FAIL sample_tick edge=%0d got=%b want=%b", edge_cnt, sample_tick, tick_exp[edge_cnt]);
            end
            while (exp_q.size() > 0 && exp_q[0].e < edge_cnt) begin
                p = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_pulse edge=%0d got=none want press=%b release=%b", p.e, p.press, p.rel);
            end
            if (btn_press !== '0 || btn_release !== '0) begin
                n_cmp++;
                if (exp_q.size() > 0 && exp_q[0].e == edge_cnt) begin
                    p = exp_q.pop_front();
                    if (btn_press !== p.press || btn_release !== p.rel || btn_level !== p.lvl) begin
                        n_bad++;
                        $display("FAIL pulse edge=%0d got p=%b r=%b l=%b want p=%b r=%b l=%b",
                                 edge_cnt, btn_press, btn_release, btn_level, p.press, p.rel, p.lvl);
                    end
                end else begin
                    n_bad++;
                    $display("FAIL unexpected_pulse edge=%0d got press=%b release=%b want none",
                             edge_cnt, btn_press, btn_release);
                end
            end
        end
    end

    initial begin
        int len;
        logic r;
        rst_n = 1'b0;
        btn_raw = '0;
        // Reset held with both buttons down, then fresh presses after release
        drive(3, 1'b0, 2'b11);
        drive(24, 1'b1, 2'b11);
        drive(24, 1'b1, 2'b10);
        drive(24, 1'b1, 2'b11);
        drive(24, 1'b1, 2'b10);
        // Bounce on ch0: 2 ticks high, 1 low, then held
        drive(8, 1'b1, 2'b11);
        drive(4, 1'b1, 2'b10);
        drive(16, 1'b1, 2'b11);
        drive(24, 1'b1, 2'b00);
        drive(24, 1'b1, 2'b11);
        drive(24, 1'b1, 2'b00);
        // Reset in the middle of a check, then a full debounce again
        drive(11, 1'b1, 2'b11);
        drive(2, 1'b0, 2'b11);
        drive(24, 1'b1, 2'b11);
        drive(24, 1'b1, 2'b00);
        repeat (60) begin
            len = $urandom_range(1, 30);
            r = ($urandom_range(0, 19) != 0);
            drive(r ? len : $urandom_range(1, 3), r, NB'($urandom));
        end
        repeat (300) begin
            drive($urandom_range(1, 6), 1'b1, NB'($urandom));
        end
        drive(40, 1'b1, btn_raw);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_pulses got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
